// File: rtl/tetris_ps2_pkg.sv
// Shared scan codes, receiver state encoding and command types for the
// PS/2 tetris control path.
package tetris_ps2_pkg;

   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_BRK   = 8'hF0;
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_RIGHT = 8'h74;
   localparam logic [7:0] SC_DOWN  = 8'h72;
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_SPACE = 8'h29;
   localparam logic [7:0] SC_Z     = 8'h1A;
   localparam logic [7:0] SC_X     = 8'h22;
   localparam logic [7:0] SC_R     = 8'h2D;

   // Held-bit slots for the keys that must not auto-repeat.
   localparam int HK_DROP   = 0;
   localparam int HK_ROTL   = 1;
   localparam int HK_ROTR_X = 2;
   localparam int HK_ROTR_E = 3;
   localparam int HK_RESET  = 4;
   localparam int HK_NUM    = 5;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_DATA,
      RX_PARITY,
      RX_STOP
   } rx_state_e;

   typedef struct packed {
      logic left;
      logic right;
      logic down;
      logic drop;
      logic rotl;
      logic rotr;
      logic rst;
   } cmd_t;

   function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 byte receiver: input synchronisers, ps2_clk debounce filter,
// start/data/parity/stop framing and inter-edge timeout.
module ps2_rx
   import tetris_ps2_pkg::*;
#(
   parameter int unsigned FILTER_LEN = 8,
   parameter int unsigned TIMEOUT    = 20000
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic [7:0] byte_o,
   output logic       byte_valid_o,
   output logic       byte_error_o
);

   localparam int unsigned FCW = $clog2(FILTER_LEN + 1);
   localparam int unsigned TW  = $clog2(TIMEOUT + 2);

   logic [1:0]     clk_sync_q, dat_sync_q;
   logic           filt_q, filt_d;
   logic [FCW-1:0] fcnt_q, fcnt_d;
   logic           fall, sbit, tmo_hit;

   rx_state_e      state_q, state_d;
   logic [7:0]     sh_q;
   logic [2:0]     bcnt_q;
   logic           par_q;
   logic [TW-1:0]  tmo_q;

   logic [7:0]     byte_q;
   logic           valid_q, valid_d;
   logic           error_q, error_d;

   assign sbit    = dat_sync_q[1];
   assign fall    = filt_q & ~filt_d;
   assign tmo_hit = (state_q != RX_IDLE) && (tmo_q == TW'(TIMEOUT)) && !fall;

   // Filtered clock only moves after FILTER_LEN consecutive disagreeing samples.
   always_comb begin
      filt_d = filt_q;
      fcnt_d = '0;
      if (clk_sync_q[1] != filt_q) begin
         if (fcnt_q == FCW'(FILTER_LEN - 1)) filt_d = clk_sync_q[1];
         else                                fcnt_d = fcnt_q + FCW'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         clk_sync_q <= '1;
         dat_sync_q <= '1;
         filt_q     <= 1'b1;
         fcnt_q     <= '0;
      end else begin
         clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
         dat_sync_q <= {dat_sync_q[0], ps2_data_i};
         filt_q     <= filt_d;
         fcnt_q     <= fcnt_d;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= RX_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (tmo_hit) begin
         state_d = RX_IDLE;
      end else if (fall) begin
         unique case (state_q)
            RX_IDLE:   if (!sbit) state_d = RX_DATA;
            RX_DATA:   if (bcnt_q == 3'd7) state_d = RX_PARITY;
            RX_PARITY: state_d = RX_STOP;
            RX_STOP:   state_d = RX_IDLE;
            default:   state_d = RX_IDLE;
         endcase
      end
   end

   always_comb begin
      valid_d = 1'b0;
      error_d = 1'b0;
      if (tmo_hit) begin
         error_d = 1'b1;
      end else if (fall && state_q == RX_STOP) begin
         if (odd_parity_ok(sh_q, par_q) && sbit) valid_d = 1'b1;
         else                                    error_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sh_q    <= '0;
         bcnt_q  <= '0;
         par_q   <= 1'b0;
         tmo_q   <= '0;
         byte_q  <= '0;
         valid_q <= 1'b0;
         error_q <= 1'b0;
      end else begin
         if (fall || state_q == RX_IDLE) tmo_q <= '0;
         else if (tmo_q != TW'(TIMEOUT)) tmo_q <= tmo_q + TW'(1);
         if (fall) begin
            if (state_q == RX_IDLE) bcnt_q <= '0;
            if (state_q == RX_DATA) begin
               sh_q   <= {sbit, sh_q[7:1]};
               bcnt_q <= bcnt_q + 3'd1;
            end
            if (state_q == RX_PARITY) par_q <= sbit;
         end
         if (valid_d) byte_q <= sh_q;
         valid_q <= valid_d;
         error_q <= error_d;
      end
   end

   assign byte_o       = byte_q;
   assign byte_valid_o = valid_q;
   assign byte_error_o = error_q;

endmodule

// File: rtl/ps2_tetris_controls.sv
// PS/2 keyboard to tetris command pulses: E0/F0 prefix tracking, key map
// and held-key repeat suppression on top of the ps2_rx byte receiver.
module ps2_tetris_controls
   import tetris_ps2_pkg::*;
#(
   parameter int unsigned FILTER_LEN = 8,
   parameter int unsigned TIMEOUT    = 20000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       move_left,
   output logic       move_right,
   output logic       move_down,
   output logic       drop,
   output logic       rotate_left,
   output logic       rotate_right,
   output logic       reset_game,
   output logic       frame_error,
   output logic [7:0] last_code
);

   logic [7:0]        rx_byte;
   logic              byte_valid, byte_error;

   logic              ext_q, ext_d, brk_q, brk_d;
   logic [HK_NUM-1:0] held_q, held_d, hk_mask, hk_new;
   logic [7:0]        last_q, last_d;
   cmd_t              cmd_q, cmd_d;
   logic              ferr_q;

   ps2_rx #(
      .FILTER_LEN (FILTER_LEN),
      .TIMEOUT    (TIMEOUT)
   ) u_rx (
      .clk_i        (clk),
      .rst_i        (reset),
      .ps2_clk_i    (ps2_clk),
      .ps2_data_i   (ps2_data),
      .byte_o       (rx_byte),
      .byte_valid_o (byte_valid),
      .byte_error_o (byte_error)
   );

   assign hk_new = hk_mask & ~held_q;

   always_comb begin
      ext_d   = ext_q;
      brk_d   = brk_q;
      held_d  = held_q;
      last_d  = last_q;
      cmd_d   = '0;
      hk_mask = '0;
      if (byte_error) begin
         ext_d = 1'b0;
         brk_d = 1'b0;
      end else if (byte_valid) begin
         last_d = rx_byte;
         if (rx_byte == SC_EXT) begin
            ext_d = 1'b1;
         end else if (rx_byte == SC_BRK) begin
            brk_d = 1'b1;
         end else begin
            ext_d = 1'b0;
            brk_d = 1'b0;
            unique case ({ext_q, rx_byte})
               {1'b1, SC_LEFT}:  cmd_d.left  = ~brk_q;
               {1'b1, SC_RIGHT}: cmd_d.right = ~brk_q;
               {1'b1, SC_DOWN}:  cmd_d.down  = ~brk_q;
               {1'b1, SC_UP}:    hk_mask[HK_ROTR_E] = 1'b1;
               {1'b0, SC_X}:     hk_mask[HK_ROTR_X] = 1'b1;
               {1'b0, SC_Z}:     hk_mask[HK_ROTL]   = 1'b1;
               {1'b0, SC_SPACE}: hk_mask[HK_DROP]   = 1'b1;
               {1'b0, SC_R}:     hk_mask[HK_RESET]  = 1'b1;
               default: ;
            endcase
            if (brk_q) begin
               held_d = held_q & ~hk_mask;
            end else begin
               held_d     = held_q | hk_mask;
               cmd_d.drop = hk_new[HK_DROP];
               cmd_d.rotl = hk_new[HK_ROTL];
               cmd_d.rotr = hk_new[HK_ROTR_X] | hk_new[HK_ROTR_E];
               cmd_d.rst  = hk_new[HK_RESET];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ext_q  <= 1'b0;
         brk_q  <= 1'b0;
         held_q <= '0;
         last_q <= '0;
         cmd_q  <= '0;
         ferr_q <= 1'b0;
      end else begin
         ext_q  <= ext_d;
         brk_q  <= brk_d;
         held_q <= held_d;
         last_q <= last_d;
         cmd_q  <= cmd_d;
         ferr_q <= byte_error;
      end
   end

   assign move_left    = cmd_q.left;
   assign move_right   = cmd_q.right;
   assign move_down    = cmd_q.down;
   assign drop         = cmd_q.drop;
   assign rotate_left  = cmd_q.rotl;
   assign rotate_right = cmd_q.rotr;
   assign reset_game   = cmd_q.rst;
   assign frame_error  = ferr_q;
   assign last_code    = last_q;

endmodule

// File: doc/ps2_tetris_controls.md
# ps2_tetris_controls

Receives PS/2 keyboard frames (scan-code set 2) and turns key presses into the single-cycle game command pulses consumed by the tetris top level: move_left, move_right, move_down, drop, rotate_left, rotate_right and reset_game. It sits between the board's PS/2 connector and the game, in the `clk` domain. It performs PS/2 signal synchronisation, filtering, bit-level reception, prefix (E0/F0) decoding and key-repeat suppression.

## Interface
Parameters:
- FILTER_LEN, 8: consecutive identical synchronised samples required before the filtered ps2_clk changes.
- TIMEOUT, 20000: clk cycles allowed between filtered ps2_clk falling edges inside a frame (200 µs at 100 MHz).

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-high; clears all state.
- ps2_clk  in  1  raw PS/2 clock, asynchronous to clk.
- ps2_data  in  1  raw PS/2 data, asynchronous to clk.
- move_left, move_right, move_down  out  1 each  one-cycle command pulses.
- drop, rotate_left, rotate_right  out  1 each  one-cycle command pulses.
- reset_game  out  1  one-cycle pulse.
- frame_error  out  1  one-cycle pulse on a rejected frame.
- last_code  out  8  last correctly received byte (debug).

## Operation
- ps2_clk and ps2_data each pass through a 2-flop synchroniser. ps2_clk is then debounced: the filtered value changes only after FILTER_LEN equal samples.
- A bit is sampled from synchronised ps2_data on each filtered falling edge.
- Receiver FSM: IDLE → DATA (8 bits, LSB first) → PARITY → STOP → IDLE.
  - In IDLE, a start bit of 1 is ignored and the FSM stays in IDLE.
  - Parity is odd: the 8 data bits plus the parity bit must contain an odd number of ones.
  - The stop bit must be 1.
  - Bad parity or a bad stop bit discards the byte, pulses frame_error, and clears the prefix flags.
- Timeout: if more than TIMEOUT cycles elapse between edges while not in IDLE, the FSM returns to IDLE, pulses frame_error and clears the prefix flags.
- Decoder state: flags `ext` (set by E0) and `brk` (set by F0). Any non-prefix byte is decoded against both flags, then both flags clear.
- Key map. Make codes pulse the listed command; break codes (brk=1) never pulse.
  - E0 6B → move_left; E0 74 → move_right; E0 72 → move_down.
  - E0 75 → rotate_right; 22 (X) → rotate_right; 1A (Z) → rotate_left.
  - 29 (space) → drop; 2D (R) → reset_game.
  - The same code with ext mismatched is unmapped.
- Repeat handling:
  - Move keys pulse on every make, including typematic repeats.
  - drop, rotate_left, rotate_right and reset_game keep a held bit per key. They pulse only when the held bit is 0, then set it. The matching break code clears it.
  - E0 75 and 22 have separate held bits.
- Unmapped codes, including E1 sequences, produce no pulse and still clear ext/brk.
- last_code updates on every good byte, prefixes included.

## Timing
- Reset values: all pulse outputs 0, last_code 8'h00, FSM IDLE, ext/brk/held bits 0.
- Reset asserted mid-frame abandons the frame with no pulse. Reception restarts with the next start bit after reset deasserts.
- Synchronisation plus filtering adds 2+FILTER_LEN cycles between a raw ps2_clk fall and the filtered falling edge.
- The byte is registered in the cycle after the stop-bit filtered falling edge. The command pulse or frame_error follows in the next cycle. Total: 2 cycles after the stop-bit filtered edge.
- Every pulse is exactly one clk cycle high. At most one command pulse fires per byte.
- A reset_game pulse does not clear the held bits of other keys.

## Structure
- Shared package tetris_ps2_pkg holds:
  - scan-code localparams (SC_EXT=8'hE0, SC_BRK=8'hF0, SC_LEFT, SC_RIGHT, SC_DOWN, SC_UP, SC_SPACE, SC_Z, SC_X, SC_R);
  - the receiver state encoding.
- Sub-module ps2_rx contains the synchroniser, filter, bit FSM, parity and timeout logic. It outputs byte[7:0], byte_valid and byte_error as one-cycle pulses.
- The top level contains the prefix and held-key decoder.

## Test plan
- Frame 0x29 with parity 0 → drop high for exactly 1 cycle; no other pulse; last_code=8'h29.
- Bytes E0 6B → one move_left pulse. Then E0 F0 6B → no pulse. Then 6B alone (unextended) → no pulse.
- 1A, 1A → one rotate_left pulse only. Then F0 1A, 1A → a second pulse.
- E0, then 0x74 sent with parity 0 (wrong) → frame_error pulse, no move_right. Then 74 alone → no pulse, because ext was cleared.
- Stop ps2_clk after 4 data bits for TIMEOUT+100 cycles → frame_error pulse, FSM back in IDLE. Then E0 72 → move_down pulse.
- Assert reset during bit 5 of 0x2D → all outputs 0 and no reset_game pulse. After release, a full 0x2D frame → one reset_game pulse.
